// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Optional early termination on dividend leading zeros: define ITER_DIV_EARLY_EN.
module iter_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div0_o
);

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH:0]     work_q, work_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_quot_q, neg_quot_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 div0_q, div0_d;

  logic                 accept;
  logic                 dividend_neg, divisor_neg;
  logic [WIDTH-1:0]     dividend_mag, divisor_mag;
  logic [2*WIDTH:0]     work_init;
  logic [CW-1:0]        cnt_init;
  logic [2*WIDTH:0]     shifted;
  logic [WIDTH+1:0]     diff;
  logic [WIDTH-1:0]     quot, rem, quot_fix, rem_fix;

`ifdef ITER_DIV_EARLY_EN
  logic [CW-1:0]        lz;

  // Higher set bits overwrite lower ones, so the last hit is the MSB.
  function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = LAST;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) n = CW'(WIDTH - 1 - i);
    end
    return n;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FREE;
      work_q     <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      div0_q     <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE: begin
        if (accept) state_d = (opdata2_i == '0) ? BY_ZERO : ON;
      end
      BY_ZERO: state_d = END;
      ON: begin
        if (annul_i)            state_d = FREE;
        else if (cnt_q == LAST) state_d = END;
      end
      END: begin
        if (!start_i) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_comb begin
    accept       = start_i && !annul_i;
    dividend_neg = signed_div_i && opdata1_i[WIDTH-1];
    divisor_neg  = signed_div_i && opdata2_i[WIDTH-1];
    dividend_mag = dividend_neg ? -opdata1_i : opdata1_i;
    divisor_mag  = divisor_neg  ? -opdata2_i : opdata2_i;

`ifdef ITER_DIV_EARLY_EN
    // Leading zeros produce zero quotient bits; skip them but always run one step.
    lz        = lzc(dividend_mag);
    work_init = {{(WIDTH+1){1'b0}}, dividend_mag} << lz;
    cnt_init  = (lz == LAST) ? LAST - CW'(1) : lz;
`else
    work_init = {{(WIDTH+1){1'b0}}, dividend_mag};
    cnt_init  = '0;
`endif

    // Partial remainder stays below the divisor, so the top bit never carries data.
    shifted  = work_q << 1;
    diff     = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, dvsr_q};
    quot     = work_q[WIDTH-1:0];
    rem      = work_q[2*WIDTH-1:WIDTH];
    quot_fix = neg_quot_q ? -quot : quot;
    rem_fix  = neg_rem_q  ? -rem  : rem;
  end

  always_comb begin
    work_d     = work_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    div0_d     = div0_q;
    case (state_q)
      FREE: begin
        if (accept) begin
          work_d     = work_init;
          dvsr_d     = divisor_mag;
          cnt_d      = cnt_init;
          neg_quot_d = dividend_neg ^ divisor_neg;
          neg_rem_d  = dividend_neg;
        end
      end
      BY_ZERO: begin
        result_d = '0;
        div0_d   = 1'b1;
        ready_d  = 1'b1;
        cnt_d    = '0;
      end
      ON: begin
        if (annul_i) begin
          cnt_d  = '0;
          work_d = '0;
        end else if (cnt_q != LAST) begin
          work_d = diff[WIDTH+1] ? shifted
                                 : {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
          cnt_d  = cnt_q + CW'(1);
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
          cnt_d    = '0;
        end
      end
      END: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          div0_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_o   = (state_q == ON) || (state_q == BY_ZERO);
    ready_o  = ready_q;
    div0_o   = div0_q;
    result_o = result_q;
  end

endmodule
